// File: rtl/stall_mem_ctrl_if.sv
// Processor-side bus of the stalling data memory: request, address/data and the
// stall/done handshake back to the pipeline.
interface stall_mem_ctrl_if #(
   parameter int DATA_W = 16
);
   logic              req_rd;
   logic              req_wr;
   logic [15:0]       addr;
   logic [DATA_W-1:0] wr_data;
   logic [DATA_W-1:0] rd_data;
   logic              stall;
   logic              done;
   logic              err;

   modport master (output req_rd, req_wr, addr, wr_data,
                   input  rd_data, stall, done, err);
   modport slave  (input  req_rd, req_wr, addr, wr_data,
                   output rd_data, stall, done, err);
endinterface

// File: rtl/stall_mem_ctrl.sv
// Multi-cycle data memory behind the pipeline's memory stage: accepts one access,
// stalls the pipeline for LATENCY cycles, then pulses done with the read result.
module stall_mem_ctrl #(
   parameter int DATA_W     = 16,
   parameter int DEPTH_LOG2 = 10,
   parameter int LATENCY    = 4
) (
   input logic             clk,
   input logic             rst,
   stall_mem_ctrl_if.slave bus
);
   localparam int         DEPTH      = 1 << DEPTH_LOG2;
   localparam logic [3:0] TIMER_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DONE
   } state_t;

   state_t                  state;
   logic [3:0]              timer;
   logic                    op_wr_q;
   logic [DEPTH_LOG2-1:0]   idx_q;
   logic [DATA_W-1:0]       wdata_q;
   logic [DATA_W-1:0]       rd_data_q;
   logic                    done_q;
   logic                    err_q;

   logic [DATA_W-1:0]       mem [DEPTH];

   logic                    one_req;
   logic                    both_req;
   logic                    accept;
   logic [DEPTH_LOG2-1:0]   live_idx;
   logic                    fire;
   logic                    fire_wr;
   logic [DEPTH_LOG2-1:0]   fire_idx;
   logic [DATA_W-1:0]       fire_wdata;
   logic                    unused_addr_hi;

   assign one_req        = bus.req_rd ^ bus.req_wr;
   assign both_req       = bus.req_rd & bus.req_wr;
   assign accept         = (state == IDLE) && one_req;
   // addr[0] only flags misalignment; high bits alias onto the same array words.
   assign live_idx       = bus.addr[DEPTH_LOG2:1];
   assign unused_addr_hi = ^bus.addr[15:DEPTH_LOG2+1];

   // The array access happens on the timer-expiry edge of WAIT, or on the acceptance
   // edge itself when there is no wait phase, in which case the live bus is used.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      fire       = 1'b0;
      fire_wr    = op_wr_q;
      fire_idx   = idx_q;
      fire_wdata = wdata_q;
      if (state == WAIT && timer == 4'd0) begin
         fire = 1'b1;
      end else if (accept && LATENCY == 0) begin
         fire       = 1'b1;
         fire_wr    = bus.req_wr;
         fire_idx   = live_idx;
         fire_wdata = bus.wr_data;
      end
   end

   // Stall must freeze the pipeline in the very cycle the request is seen, so it
   // cannot wait for a register.
   assign bus.stall   = accept || (state == WAIT);
   assign bus.done    = done_q;
   assign bus.err     = err_q;
   assign bus.rd_data = rd_data_q;

   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
      if (!rst) begin
         state     <= IDLE;
         timer     <= 4'd0;
         op_wr_q   <= 1'b0;
         idx_q     <= '0;
         wdata_q   <= '0;
         rd_data_q <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  op_wr_q <= bus.req_wr;
                  idx_q   <= live_idx;
                  wdata_q <= bus.wr_data;
                  if (bus.addr[0]) err_q <= 1'b1;
                  if (LATENCY == 0) begin
                     state  <= DONE;
                     done_q <= 1'b1;
                  end else begin
                     timer <= TIMER_LOAD;
                     state <= WAIT;
                  end
               end else if (both_req) begin
                  err_q <= 1'b1;
               end
            end
            WAIT: begin
               if (timer == 4'd0) begin
                  state  <= DONE;
                  done_q <= 1'b1;
               end else begin
                  timer <= timer - 4'd1;
               end
            end
            // The request still held here is the one just completed; never re-accept it.
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
         if (fire && !fire_wr) rd_data_q <= mem[fire_idx];
      end
   end

   // NOTE: the word array has no reset; contents survive rst, only the write strobe is gated by it.
   always_ff @(posedge clk) begin
      if (rst && fire && fire_wr) mem[fire_idx] <= fire_wdata;
   end

endmodule
